sha256_compress: RTL

SHA-256 compression engine: the consumer side of the round-constant lookup. It drives a 6-bit round index to the K-constant ROM and consumes the returned 32-bit constant in the same cycle. It runs 64 rounds over one 512-bit pre-padded message block, then adds the result to the chaining value. It sits between the padding/block-feed logic and the digest output register in the hashing top level.

---
 rtl/sha256_compress_pkg.sv | 46 ++++
 rtl/sha256_compress_if.sv | 20 ++
 rtl/sha256_w_schedule.sv | 42 ++++
 rtl/sha256_compress.sv | 112 +++++++++++
 4 files changed

// File: rtl/sha256_compress_pkg.sv
// Shared SHA-256 definitions: initial hash value, FSM state encoding and
// the round/schedule mixing functions used by the compression engine.
package sha256_compress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [255:0] H0_INIT = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Block-feed side of the compression engine: request, message/chaining
// inputs and the status/digest outputs.
interface sha256_compress_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         busy;
    logic         done;
    logic [255:0] digest_out;

    modport slave (
        input  start, block_in, hash_in,
        output busy, done, digest_out
    );

    modport master (
        output start, block_in, hash_in,
        input  busy, done, digest_out
    );
endinterface

// File: rtl/sha256_w_schedule.sv
// 16-word sliding message-schedule window; w_t is the word consumed by the
// current round, and each shift appends the next expanded word at the top.
module sha256_w_schedule
    import sha256_compress_pkg::*;
(
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    output logic [31:0]  w_t
);

    logic [31:0] w_reg     [16];
    logic [31:0] w_loaded  [16];
    logic [31:0] w_shifted [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        assign w_loaded[gi] = block_in[511-32*gi -: 32];
        if (gi < 15) begin : g_move
            assign w_shifted[gi] = w_reg[gi+1];
        end else begin : g_expand
            assign w_shifted[gi] = small_sigma1(w_reg[14]) + w_reg[9]
                                 + small_sigma0(w_reg[1]) + w_reg[0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (srst) begin
                w_reg[i] <= '0;
            end else if (load) begin
                w_reg[i] <= w_loaded[i];
            end else if (shift) begin
                w_reg[i] <= w_shifted[i];
            end
        end
    end

    assign w_t = w_reg[0];

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: 64 single-cycle rounds against an external
// combinational K ROM, then the feed-forward add into digest_out.
module sha256_compress
    import sha256_compress_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    sha256_compress_if.slave bus,
    output logic [5:0]       round_n,
    input  logic [31:0]      k_in
);

    state_t       state_reg, state_next;
    logic [5:0]   t_reg;
    logic [31:0]  work_reg  [8];
    logic [31:0]  work_next [8];
    logic [31:0]  hash_reg  [8];
    logic [255:0] digest_reg;
    logic [255:0] digest_next;
    logic [31:0]  w_t;
    logic [31:0]  t1, t2;
    logic         load, shift;

    assign load  = (state_reg == ST_IDLE) && bus.start;
    assign shift = (state_reg == ST_ROUND);

    sha256_w_schedule u_w_schedule (
        .clk      (clk),
        .srst     (rst),
        .load     (load),
        .shift    (shift),
        .block_in (bus.block_in),
        .w_t      (w_t)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.start) state_next = ST_ROUND;
            ST_ROUND: if (t_reg == 6'd63) state_next = ST_FINAL;
            ST_FINAL: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Working variables indexed a=0 .. h=7.
    always_comb begin
        t1 = work_reg[7] + big_sigma1(work_reg[4])
           + ch(work_reg[4], work_reg[5], work_reg[6]) + k_in + w_t;
        t2 = big_sigma0(work_reg[0]) + maj(work_reg[0], work_reg[1], work_reg[2]);
        work_next[0] = t1 + t2;
        work_next[1] = work_reg[0];
        work_next[2] = work_reg[1];
        work_next[3] = work_reg[2];
        work_next[4] = work_reg[3] + t1;
        work_next[5] = work_reg[4];
        work_next[6] = work_reg[5];
        work_next[7] = work_reg[6];
    end

    // Digest is formed from the round-63 results so it lands with FINAL.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digest
        assign digest_next[255-32*gi -: 32] = hash_reg[gi] + work_next[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_reg      <= '0;
            digest_reg <= '0;
            for (int i = 0; i < 8; i++) begin
                work_reg[i] <= '0;
                hash_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        t_reg <= '0;
                        for (int i = 0; i < 8; i++) begin
                            work_reg[i] <= bus.hash_in[255-32*i -: 32];
                            hash_reg[i] <= bus.hash_in[255-32*i -: 32];
                        end
                    end
                end
                ST_ROUND: begin
                    t_reg <= t_reg + 6'd1;
                    for (int i = 0; i < 8; i++) begin
                        work_reg[i] <= work_next[i];
                    end
                    if (t_reg == 6'd63) begin
                        digest_reg <= digest_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign round_n        = (state_reg == ST_ROUND) ? t_reg : 6'd0;
    assign bus.busy       = (state_reg != ST_IDLE);
    assign bus.done       = (state_reg == ST_FINAL);
    assign bus.digest_out = digest_reg;

endmodule
